// File: rtl/block_1_indirect_access_ctrl.sv
// APB master sequencer for block_1's indirect register window: turns one
// (index0, index1, read/write, data) request into index writes plus a data access.
module block_1_indirect_access_ctrl #(
    parameter int unsigned              ADDRESS_WIDTH     = 16,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS      = '0,
    parameter logic [6:0]               INDEX0_OFFSET     = 7'h00,
    parameter logic [6:0]               INDEX1_OFFSET     = 7'h04,
    parameter logic [6:0]               DATA_OFFSET       = 7'h10,
    parameter bit                       SKIP_CACHED_INDEX = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_write,
    input  logic [7:0]               i_req_index0,
    input  logic [7:0]               i_req_index1,
    input  logic [7:0]               i_req_wdata,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [7:0]               o_rsp_rdata,
    output logic                     o_rsp_error,
    output logic                     o_psel,
    output logic                     o_penable,
    output logic                     o_pwrite,
    output logic [ADDRESS_WIDTH-1:0] o_paddr,
    output logic [2:0]               o_pprot,
    output logic [31:0]              o_pwdata,
    output logic [3:0]               o_pstrb,
    input  logic                     i_pready,
    input  logic [31:0]              i_prdata,
    input  logic                     i_pslverr
);

    localparam int unsigned SUM_WIDTH = ADDRESS_WIDTH + 8;

    // Offsets are added in a wider type and then truncated to the bus width.
    localparam logic [ADDRESS_WIDTH-1:0] INDEX0_ADDR =
        ADDRESS_WIDTH'(SUM_WIDTH'(BASE_ADDRESS) + SUM_WIDTH'(INDEX0_OFFSET));
    localparam logic [ADDRESS_WIDTH-1:0] INDEX1_ADDR =
        ADDRESS_WIDTH'(SUM_WIDTH'(BASE_ADDRESS) + SUM_WIDTH'(INDEX1_OFFSET));
    localparam logic [ADDRESS_WIDTH-1:0] DATA_ADDR =
        ADDRESS_WIDTH'(SUM_WIDTH'(BASE_ADDRESS) + SUM_WIDTH'(DATA_OFFSET));

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_IDX0_SETUP  = 3'd1,
        ST_IDX0_ACCESS = 3'd2,
        ST_IDX1_SETUP  = 3'd3,
        ST_IDX1_ACCESS = 3'd4,
        ST_DATA_SETUP  = 3'd5,
        ST_DATA_ACCESS = 3'd6,
        ST_RESP        = 3'd7
    } state_t;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic                     write;
        logic [31:0]              wdata;
        logic [3:0]               strb;
    } apb_cmd_t;

    function automatic logic index_must_write(input logic       cache_valid,
                                              input logic [7:0] cache_value,
                                              input logic [7:0] req_value);
        return (SKIP_CACHED_INDEX == 1'b0) || !cache_valid || (cache_value != req_value);
    endfunction

    function automatic apb_cmd_t index_cmd(input logic [ADDRESS_WIDTH-1:0] addr,
                                           input logic [7:0]               value);
        apb_cmd_t cmd;
        cmd.addr  = addr;
        cmd.write = 1'b1;
        cmd.wdata = {24'h00_0000, value};
        cmd.strb  = 4'hF;
        return cmd;
    endfunction

    function automatic apb_cmd_t data_cmd(input logic write, input logic [7:0] wdata);
        apb_cmd_t cmd;
        cmd.addr  = DATA_ADDR;
        cmd.write = write;
        cmd.wdata = write ? {24'h00_0000, wdata} : 32'h0000_0000;
        cmd.strb  = write ? 4'hF : 4'h0;
        return cmd;
    endfunction

    state_t     state_r;
    apb_cmd_t   cmd_r;
    logic       psel_r;
    logic       penable_r;
    logic       req_ready_r;
    logic       rsp_valid_r;
    logic [7:0] rsp_rdata_r;
    logic       rsp_error_r;
    logic       req_write_r;
    logic [7:0] req_index0_r;
    logic [7:0] req_index1_r;
    logic [7:0] req_wdata_r;
    logic [1:0] cache_valid_r;
    logic [7:0] cache0_r;
    logic [7:0] cache1_r;

    logic       cur_write_s;
    logic [7:0] cur_index0_s;
    logic [7:0] cur_index1_s;
    logic [7:0] cur_wdata_s;
    logic       need_idx0_s;
    logic       need_idx1_s;
    apb_cmd_t   idx0_cmd_s;
    apb_cmd_t   idx1_cmd_s;
    apb_cmd_t   data_cmd_s;

    // Request view (live inputs while idle, captured copy afterwards) and next-step decode.
    always_comb begin
        cur_write_s  = req_write_r;
        cur_index0_s = req_index0_r;
        cur_index1_s = req_index1_r;
        cur_wdata_s  = req_wdata_r;
        if (state_r == ST_IDLE) begin
            cur_write_s  = i_req_write;
            cur_index0_s = i_req_index0;
            cur_index1_s = i_req_index1;
            cur_wdata_s  = i_req_wdata;
        end else begin
            cur_write_s  = req_write_r;
            cur_index0_s = req_index0_r;
            cur_index1_s = req_index1_r;
            cur_wdata_s  = req_wdata_r;
        end
        need_idx0_s = index_must_write(cache_valid_r[0], cache0_r, cur_index0_s);
        need_idx1_s = index_must_write(cache_valid_r[1], cache1_r, cur_index1_s);
        idx0_cmd_s  = index_cmd(INDEX0_ADDR, cur_index0_s);
        idx1_cmd_s  = index_cmd(INDEX1_ADDR, cur_index1_s);
        data_cmd_s  = data_cmd(cur_write_s, cur_wdata_s);
    end

    // Sequencer FSM with registered APB and handshake outputs and the index cache.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r       <= ST_IDLE;
            cmd_r         <= '0;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            req_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= 8'h00;
            rsp_error_r   <= 1'b0;
            req_write_r   <= 1'b0;
            req_index0_r  <= 8'h00;
            req_index1_r  <= 8'h00;
            req_wdata_r   <= 8'h00;
            cache_valid_r <= 2'b00;
            cache0_r      <= 8'h00;
            cache1_r      <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        req_write_r  <= i_req_write;
                        req_index0_r <= i_req_index0;
                        req_index1_r <= i_req_index1;
                        req_wdata_r  <= i_req_wdata;
                        req_ready_r  <= 1'b0;
                        rsp_rdata_r  <= 8'h00;
                        rsp_error_r  <= 1'b0;
                        psel_r       <= 1'b1;
                        penable_r    <= 1'b0;
                        if (need_idx0_s) begin
                            state_r <= ST_IDX0_SETUP;
                            cmd_r   <= idx0_cmd_s;
                        end else if (need_idx1_s) begin
                            state_r <= ST_IDX1_SETUP;
                            cmd_r   <= idx1_cmd_s;
                        end else begin
                            state_r <= ST_DATA_SETUP;
                            cmd_r   <= data_cmd_s;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_IDX0_SETUP: begin
                    state_r   <= ST_IDX0_ACCESS;
                    penable_r <= 1'b1;
                end
                ST_IDX0_ACCESS: begin
                    if (i_pready) begin
                        penable_r <= 1'b0;
                        if (i_pslverr) begin
                            // A failed index write leaves the slave's index state unknown.
                            cache_valid_r <= 2'b00;
                            rsp_error_r   <= 1'b1;
                            psel_r        <= 1'b0;
                            rsp_valid_r   <= 1'b1;
                            state_r       <= ST_RESP;
                        end else begin
                            cache0_r         <= req_index0_r;
                            cache_valid_r[0] <= 1'b1;
                            if (need_idx1_s) begin
                                state_r <= ST_IDX1_SETUP;
                                cmd_r   <= idx1_cmd_s;
                            end else begin
                                state_r <= ST_DATA_SETUP;
                                cmd_r   <= data_cmd_s;
                            end
                        end
                    end
                end
                ST_IDX1_SETUP: begin
                    state_r   <= ST_IDX1_ACCESS;
                    penable_r <= 1'b1;
                end
                ST_IDX1_ACCESS: begin
                    if (i_pready) begin
                        penable_r <= 1'b0;
                        if (i_pslverr) begin
                            cache_valid_r <= 2'b00;
                            rsp_error_r   <= 1'b1;
                            psel_r        <= 1'b0;
                            rsp_valid_r   <= 1'b1;
                            state_r       <= ST_RESP;
                        end else begin
                            cache1_r         <= req_index1_r;
                            cache_valid_r[1] <= 1'b1;
                            state_r          <= ST_DATA_SETUP;
                            cmd_r            <= data_cmd_s;
                        end
                    end
                end
                ST_DATA_SETUP: begin
                    state_r   <= ST_DATA_ACCESS;
                    penable_r <= 1'b1;
                end
                ST_DATA_ACCESS: begin
                    if (i_pready) begin
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        rsp_rdata_r <= req_write_r ? 8'h00 : i_prdata[7:0];
                        rsp_error_r <= i_pslverr;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    psel_r      <= 1'b0;
                    penable_r   <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign o_req_ready = req_ready_r;
    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_rdata = rsp_rdata_r;
    assign o_rsp_error = rsp_error_r;
    assign o_psel      = psel_r;
    assign o_penable   = penable_r;
    assign o_pwrite    = cmd_r.write;
    assign o_paddr     = cmd_r.addr;
    assign o_pwdata    = cmd_r.wdata;
    assign o_pstrb     = cmd_r.strb;
    assign o_pprot     = 3'b000;

endmodule

// File: tb/tb_block_1_indirect_access_ctrl.sv
// Self-checking bench for block_1_indirect_access_ctrl: directed plus random requests
// against a transfer-list reference model and a wait/error-injecting APB slave.
module tb_block_1_indirect_access_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_write = 1'b0;
    logic [7:0]  i_req_index0 = 8'h00;
    logic [7:0]  i_req_index1 = 8'h00;
    logic [7:0]  i_req_wdata = 8'h00;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [7:0]  o_rsp_rdata;
    logic        o_rsp_error;
    logic        o_psel;
    logic        o_penable;
    logic        o_pwrite;
    logic [15:0] o_paddr;
    logic [2:0]  o_pprot;
    logic [31:0] o_pwdata;
    logic [3:0]  o_pstrb;
    logic        i_pready = 1'b0;
    logic [31:0] i_prdata = 32'h0;
    logic        i_pslverr = 1'b0;

    block_1_indirect_access_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write),
        .i_req_index0(i_req_index0), .i_req_index1(i_req_index1), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_error(o_rsp_error), .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
        .o_paddr(o_paddr), .o_pprot(o_pprot), .o_pwdata(o_pwdata), .o_pstrb(o_pstrb),
        .i_pready(i_pready), .i_prdata(i_prdata), .i_pslverr(i_pslverr)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        err;
    } xfer_t;

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;

    // Reference model of the slave-side index registers as the DUT should believe them.
    logic [7:0] m_cache [2];
    logic       m_cv    [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) begin
            checks_passed++;
        end else begin
            checks_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic wr, input logic [7:0] i0, input logic [7:0] i1,
                          input logic [7:0] wd, input logic [7:0] rdv, input int waits,
                          input int err_kind, input int hold);
        xfer_t       xq[$];
        xfer_t       x;
        logic [7:0]  idx [2];
        logic        stop;
        logic        exp_err;
        logic [7:0]  exp_rd;
        int          exp_lat;
        int          cyc;
        int          k;
        int          wcnt;
        logic        seen;
        logic [15:0] s_addr;
        logic        s_wr;
        logic [31:0] s_wdata;
        logic [3:0]  s_strb;
        logic [31:0] rnd;

        // Expected transfer list: index writes only where the cache disagrees.
        idx[0] = i0; idx[1] = i1;
        stop = 1'b0; exp_err = 1'b0; exp_rd = 8'h00;
        for (int n = 0; n < 2; n++) begin
            if (!stop && (!m_cv[n] || m_cache[n] != idx[n])) begin
                x.addr  = (n == 0) ? 16'h0000 : 16'h0004;
                x.wr    = 1'b1;
                x.wdata = {24'h0, idx[n]};
                x.strb  = 4'hF;
                x.err   = (err_kind == n + 1);
                xq.push_back(x);
                if (x.err) begin
                    stop = 1'b1; exp_err = 1'b1; m_cv[0] = 1'b0; m_cv[1] = 1'b0;
                end else begin
                    m_cache[n] = idx[n]; m_cv[n] = 1'b1;
                end
            end
        end
        if (!stop) begin
            x.addr  = 16'h0010;
            x.wr    = wr;
            x.wdata = wr ? {24'h0, wd} : 32'h0;
            x.strb  = wr ? 4'hF : 4'h0;
            x.err   = (err_kind == 3);
            xq.push_back(x);
            exp_err = x.err;
            exp_rd  = wr ? 8'h00 : rdv;
        end
        exp_lat = 1 + 2 * xq.size() + waits;

        @(negedge i_clk);
        check("req_ready_idle", {31'h0, o_req_ready}, 32'h1);
        i_req_valid = 1'b1; i_req_write = wr; i_req_index0 = i0;
        i_req_index1 = i1;  i_req_wdata = wd;
        @(negedge i_clk);
        // Keep offering junk while busy; it must not be captured.
        rnd = $urandom();
        i_req_write = rnd[0]; i_req_index0 = rnd[15:8]; i_req_index1 = rnd[23:16];
        i_req_wdata = rnd[31:24];
        cyc = 1; k = -1; wcnt = 0; seen = 1'b0;
        s_addr = 16'h0; s_wr = 1'b0; s_wdata = 32'h0; s_strb = 4'h0;
        while (cyc <= exp_lat + 20 && !seen) begin
            if (o_rsp_valid) begin
                seen = 1'b1;
            end else begin
                if (o_psel && !o_penable) begin
                    k++;
                    i_pready = 1'b0; i_pslverr = 1'b0;
                    s_addr = o_paddr; s_wr = o_pwrite; s_wdata = o_pwdata; s_strb = o_pstrb;
                    check("pprot", {29'h0, o_pprot}, 32'h0);
                    if (k < xq.size()) begin
                        check("xfer_addr", {16'h0, o_paddr}, {16'h0, xq[k].addr});
                        check("xfer_write", {31'h0, o_pwrite}, {31'h0, xq[k].wr});
                        check("xfer_wdata", o_pwdata, xq[k].wdata);
                        check("xfer_strb", {28'h0, o_pstrb}, {28'h0, xq[k].strb});
                    end else begin
                        check("extra_xfer", k, xq.size() - 1);
                    end
                    wcnt = (k == 0) ? waits : 0;
                end else if (o_psel && o_penable) begin
                    check("stable_addr", {16'h0, o_paddr}, {16'h0, s_addr});
                    check("stable_wdata", o_pwdata, s_wdata);
                    check("stable_ctl", {26'h0, o_pwrite, o_pstrb, 1'b0}, {26'h0, s_wr, s_strb, 1'b0});
                    if (wcnt > 0) begin
                        wcnt--;
                        i_pready = 1'b0; i_pslverr = 1'b0;
                    end else begin
                        rnd = $urandom();
                        i_pready  = 1'b1;
                        i_pslverr = (k >= 0 && k < xq.size()) ? xq[k].err : 1'b0;
                        i_prdata  = {rnd[31:8], rdv};
                    end
                end else begin
                    i_pready = 1'b0; i_pslverr = 1'b0;
                end
                @(negedge i_clk);
                cyc++;
            end
        end
        i_pready = 1'b0; i_pslverr = 1'b0; i_req_valid = 1'b0;
        check("rsp_seen", {31'h0, seen}, 32'h1);
        check("latency", cyc, exp_lat);
        check("xfer_count", k + 1, xq.size());
        check("rsp_rdata", {24'h0, o_rsp_rdata}, {24'h0, exp_rd});
        check("rsp_error", {31'h0, o_rsp_error}, {31'h0, exp_err});
        check("psel_after", {30'h0, o_psel, o_penable}, 32'h0);
        check("req_ready_busy", {31'h0, o_req_ready}, 32'h0);
        for (int h = 0; h < hold; h++) begin
            @(negedge i_clk);
            check("hold_valid", {31'h0, o_rsp_valid}, 32'h1);
            check("hold_data", {23'h0, o_rsp_error, o_rsp_rdata}, {23'h0, exp_err, exp_rd});
            check("hold_req_ready", {31'h0, o_req_ready}, 32'h0);
        end
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
        check("rsp_done", {30'h0, o_rsp_valid, o_req_ready}, 32'h1);
    endtask

    task automatic req_with_reset(input logic [7:0] i0, input logic [7:0] i1);
        int   cyc;
        logic hit;
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_write = 1'b0; i_req_index0 = i0; i_req_index1 = i1;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        cyc = 0; hit = 1'b0;
        while (cyc < 30 && !hit) begin
            if (o_psel && o_penable && o_paddr == 16'h0010) begin
                hit = 1'b1;
            end else begin
                i_pready = o_psel && o_penable;
                i_pslverr = 1'b0;
                @(negedge i_clk);
                cyc++;
            end
        end
        check("reached_data_access", {31'h0, hit}, 32'h1);
        i_pready = 1'b0; i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("rst_psel", {30'h0, o_psel, o_penable}, 32'h0);
        check("rst_req_ready", {31'h0, o_req_ready}, 32'h1);
        m_cv[0] = 1'b0; m_cv[1] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge i_clk);
            check("rst_no_rsp", {30'h0, o_rsp_valid, o_psel}, 32'h0);
        end
    endtask

    initial begin
        logic       r_wr;
        logic [7:0] r_i0, r_i1, r_wd, r_rd;
        int         r_wait, r_err, r_hold;

        m_cv[0] = 1'b0; m_cv[1] = 1'b0; m_cache[0] = 8'h00; m_cache[1] = 8'h00;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        check("reset_req_ready", {31'h0, o_req_ready}, 32'h1);
        check("reset_rsp", {22'h0, o_rsp_valid, o_rsp_error, o_rsp_rdata}, 32'h0);
        check("reset_apb_ctl", {25'h0, o_psel, o_penable, o_pwrite, o_pstrb}, 32'h0);
        check("reset_paddr", {16'h0, o_paddr}, 32'h0);
        check("reset_pwdata", o_pwdata, 32'h0);
        check("reset_pprot", {29'h0, o_pprot}, 32'h0);

        do_req(1'b0, 8'h01, 8'h00, 8'h00, 8'hA5, 0, 0, 0);   // full sequence read
        do_req(1'b1, 8'h01, 8'h00, 8'h3C, 8'h00, 0, 0, 0);   // both cached, write
        do_req(1'b0, 8'h01, 8'h01, 8'h00, 8'h5A, 0, 0, 0);   // only index1 changes
        do_req(1'b0, 8'h02, 8'h02, 8'h00, 8'h77, 4, 0, 0);   // 4 wait states on index0
        do_req(1'b1, 8'h03, 8'h03, 8'h99, 8'h00, 0, 2, 0);   // pslverr on index1 write
        do_req(1'b0, 8'h03, 8'h03, 8'h00, 8'h12, 0, 0, 0);   // both indices rewritten
        do_req(1'b0, 8'h03, 8'h03, 8'h00, 8'hC3, 0, 3, 3);   // data error, response held
        do_req(1'b0, 8'h03, 8'h03, 8'h00, 8'h44, 0, 0, 0);   // cache survived data error
        req_with_reset(8'h07, 8'h08);
        do_req(1'b1, 8'h03, 8'h03, 8'hEE, 8'h00, 0, 0, 0);   // caches invalid after reset

        for (int it = 0; it < 40; it++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_i0   = 8'($urandom_range(0, 2));
            r_i1   = 8'($urandom_range(0, 2));
            r_wd   = 8'($urandom_range(0, 255));
            r_rd   = 8'($urandom_range(0, 255));
            r_wait = $urandom_range(0, 3);
            r_err  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            r_hold = $urandom_range(0, 2);
            do_req(r_wr, r_i0, r_i1, r_wd, r_rd, r_wait, r_err, r_hold);
        end

        if (checks_failed > 0) $display("%0d comparisons did not match", checks_failed);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
